cd_target_entry: RTL and testbench
==================================

# cd_target_entry

Target-time entry stage feeding the countdown block. Converts button actions (field select, increment, decrement with auto-repeat, load) into an H:M:S target, converts it to a 17-bit second count, and issues a one-cycle load strobe consumed as `tar_sec`/`init_en` by the countdown. Also exports the edited H:M:S fields for the display mux.

## Interface
Parameters:
- REPEAT_DELAY, 50_000_000: cycles a held up/down button must stay high before auto-repeat starts.
- REPEAT_PERIOD, 10_000_000: cycles between auto-repeat steps once repeating.
- HH_MAX, 35: maximum hours value. 35:59:59 = 129599 s must fit in 17 bits.

Ports (reset rst, synchronous, active-high; clock clk):
- clk  in  1  system clock (100 MHz).
- rst  in  1  synchronous active-high reset.
- btn_sel  in  1  debounced level; a rising edge advances the edit field.
- btn_up  in  1  debounced level; a rising edge increments the field; holding it auto-repeats.
- btn_down  in  1  debounced level; a rising edge decrements the field; holding it auto-repeats.
- btn_load  in  1  debounced level; a rising edge commits the target.
- locked  in  1  high while the countdown runs (its `state`). All edits and loads are ignored while high.
- hh  out  6  hours field, 0..HH_MAX.
- mm  out  6  minutes field, 0..59.
- ss  out  6  seconds field, 0..59.
- field  out  2  active field: 0 = SS, 1 = MM, 2 = HH. Value 3 is never produced.
- tar_sec  out  17  committed target, hh*3600 + mm*60 + ss.
- init_en  out  1  one-cycle load strobe to the countdown.

## Operation
- Edge detect: each button has a registered previous-sample flop. A rising edge is current=1 and previous=0.
- FSM states:
  - EDIT → CALC on a btn_load rising edge when locked=0.
  - CALC → FIRE unconditionally.
  - FIRE → EDIT unconditionally.
- In CALC and FIRE, all button edges and repeats are ignored; the hh/mm/ss fields are frozen.
- Field select: SS → MM → HH → SS.
- Increment wraps: ss and mm 59→0; hh HH_MAX→0. No carry into the next field.
- Decrement wraps: ss and mm 0→59; hh 0→HH_MAX. No borrow.
- btn_up and btn_down both high: no step, and the repeat counter is cleared.
- Priority within one cycle: load > sel > up/down.
  - A load edge in the same cycle as a sel or up edge causes only the load. That sel or up edge is lost.
- Auto-repeat:
  - A single counter runs while exactly one of up/down is held in EDIT with locked=0.
  - It is cleared on the initial edge and on any release.
  - When the counter reaches REPEAT_DELAY-1, one step occurs and the counter reloads to REPEAT_DELAY-REPEAT_PERIOD. After that, one step occurs every REPEAT_PERIOD cycles.
- locked=1 clears the repeat counter. Edges seen while locked are discarded, not queued.
- Conversion: in CALC, tar_sec <= hh*3600 + mm*60 + ss. Use 17-bit unsigned arithmetic with constant multiplies (shift-add acceptable). Overflow cannot occur.
- tar_sec holds its value until the next CALC. Fields keep their values after a load, so they can be re-edited.

## Timing
- Reset values: hh=mm=ss=0, field=0, tar_sec=0, init_en=0, FSM=EDIT, repeat counter=0. Edge-detect previous flops are 0.
  - A button already high at reset release therefore produces an edge on the first cycle.
- Edit latency: a rising edge sampled at clock edge N updates the field/value at N. The new value is visible from N to N+1.
- Load latency:
  - Load edge sampled at N: FSM=CALC.
  - At N+1: tar_sec updated, FSM=FIRE.
  - At N+2: init_en=1 for exactly one cycle, FSM=EDIT.
  - tar_sec is stable for at least one cycle before init_en and throughout it.
- init_en is never asserted on two consecutive cycles. The minimum spacing between strobes is 3 cycles.
- rst mid-CALC/FIRE aborts: init_en stays 0 and tar_sec resets to 0.
- locked rising during CALC/FIRE does not abort a load already in progress.

## Test plan
- Reset then sel edge ×2, up edge ×5 → field=2, hh=5. Then load → tar_sec=18000; init_en high exactly 2 cycles after the load edge, 1-cycle wide.
- Set 35:59:59 via down edges from 0 (hh 0→35, mm 0→59, ss 0→59 wraps), then load → tar_sec=129599.
- With REPEAT_DELAY=10 and REPEAT_PERIOD=4, hold btn_up for 30 cycles on SS from 58 → steps: edge (59), cycle 10 (0), then 14, 18, 22, 26, 30 → ss=5.
- btn_up and btn_down high together for 20 cycles → no change. Load and up edge in the same cycle → value unchanged, load performed.
- locked=1: sel/up/load edges → no field change, init_en never asserted. locked falls with btn_up still held → no step, since there is no new edge.
- Load edge, then rst at N+1 → init_en stays 0, tar_sec=0, all fields 0, FSM=EDIT.

Source files
------------

// File: rtl/cd_target_entry.sv
// cd_target_entry: button-driven H:M:S target editor producing a second count and a one-cycle load strobe.
module cd_target_entry #(
  parameter int REPEAT_DELAY  = 50_000_000,
  parameter int REPEAT_PERIOD = 10_000_000,
  parameter int HH_MAX        = 35
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_sel,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_load,
  input  logic        locked,
  output logic [5:0]  hh,
  output logic [5:0]  mm,
  output logic [5:0]  ss,
  output logic [1:0]  field,
  output logic [16:0] tar_sec,
  output logic        init_en
);
  typedef enum logic [1:0] {EDIT, CALC, FIRE} state_t;
  localparam int RW = $clog2(REPEAT_DELAY + 1);
  state_t state, state_nx;
  logic [3:0] btn, prev, rise;
  logic [RW-1:0] rcnt;
  logic active, one, rep, do_load, do_sel, step;
  logic [5:0] cur, top, nxt;
  always_comb begin
    btn = {btn_load, btn_down, btn_up, btn_sel};
    rise = btn & ~prev;
    active = state == EDIT && !locked;
    one = btn_up ^ btn_down;
    rep = one && rcnt == RW'(REPEAT_DELAY - 1);
    do_load = active && rise[3];
    do_sel = active && !rise[3] && rise[0];
    // load and sel both outrank a step, so an up/down edge or repeat tick in that cycle is dropped
    step = active && !rise[3] && !rise[0] && one && (rise[1] || rise[2] || rep);
    cur = field == 2'd2 ? hh : field == 2'd1 ? mm : ss;
    top = field == 2'd2 ? 6'(HH_MAX) : 6'd59;
    nxt = btn_up ? (cur == top ? 6'd0 : cur + 6'd1) : (cur == 6'd0 ? top : cur - 6'd1);
    state_nx = state == EDIT ? (do_load ? CALC : EDIT) : state == CALC ? FIRE : EDIT;
  end
  always_ff @(posedge clk)
    state <= rst ? EDIT : state_nx;
  always_ff @(posedge clk) begin
    if (rst) begin
      prev <= '0;
      rcnt <= '0;
      hh <= '0;
      mm <= '0;
      ss <= '0;
      field <= '0;
      tar_sec <= '0;
      init_en <= 1'b0;
    end else begin
      prev <= btn;
      init_en <= state == FIRE;
      if (!active || !one || rise[1] || rise[2]) rcnt <= '0;
      else rcnt <= rep ? RW'(REPEAT_DELAY - REPEAT_PERIOD) : rcnt + RW'(1);
      if (state == CALC) tar_sec <= 17'(hh) * 17'd3600 + 17'(mm) * 17'd60 + 17'(ss);
      if (do_sel) field <= field == 2'd2 ? 2'd0 : field + 2'd1;
      if (step && field == 2'd2) hh <= nxt;
      if (step && field == 2'd1) mm <= nxt;
      if (step && field == 2'd0) ss <= nxt;
    end
  end
endmodule

// File: tb/tb_cd_target_entry.sv
// tb_cd_target_entry: directed-vector self-checking bench for cd_target_entry.
module tb_cd_target_entry;
  logic clk = 1'b0, rst = 1'b1, locked = 1'b0;
  logic [3:0] b = '0;
  logic [5:0] hh, mm, ss;
  logic [1:0] field;
  logic [16:0] tar_sec;
  logic init_en;
  int passed = 0, total = 0;
  always #5 clk = ~clk;
  cd_target_entry #(.REPEAT_DELAY(10), .REPEAT_PERIOD(4), .HH_MAX(35)) dut (
    .clk(clk), .rst(rst),
    .btn_sel(b[0]), .btn_up(b[1]), .btn_down(b[2]), .btn_load(b[3]),
    .locked(locked),
    .hh(hh), .mm(mm), .ss(ss), .field(field),
    .tar_sec(tar_sec), .init_en(init_en)
  );
  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic press(input int i);
    b[i] = 1'b1;
    tick(1);
    b[i] = 1'b0;
    tick(1);
  endtask
  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask
  task automatic do_load(input string tag, input int exp, input logic with_up);
    b[3] = 1'b1;
    b[1] = with_up;
    tick(1);
    b[3] = 1'b0;
    b[1] = 1'b0;
    check({tag, "_en_n0"}, init_en, 0);
    tick(1);
    check({tag, "_tar"}, tar_sec, exp);
    check({tag, "_en_n1"}, init_en, 0);
    tick(1);
    check({tag, "_en_n2"}, init_en, 1);
    tick(1);
    check({tag, "_en_n3"}, init_en, 0);
    check({tag, "_tar_hold"}, tar_sec, exp);
  endtask
  initial begin
    tick(3);
    rst = 1'b0;
    check("rst_hh", hh, 0);
    check("rst_mm", mm, 0);
    check("rst_ss", ss, 0);
    check("rst_field", field, 0);
    check("rst_tar", tar_sec, 0);
    check("rst_en", init_en, 0);
    press(0);
    check("sel1", field, 1);
    press(0);
    check("sel2", field, 2);
    for (int i = 0; i < 5; i++) press(1);
    check("hh5", hh, 5);
    do_load("ld5h", 18000, 1'b0);
    check("field_kept", field, 2);
    do_reset();
    press(2);
    check("ss_wrap", ss, 59);
    press(0);
    press(2);
    check("mm_wrap", mm, 59);
    press(0);
    press(2);
    check("hh_wrap", hh, 35);
    press(1);
    check("hh_up_wrap", hh, 0);
    press(2);
    do_load("ldmax", 129599, 1'b0);
    do_reset();
    press(2);
    press(2);
    check("ss58", ss, 58);
    b[1] = 1'b1;
    tick(1);
    check("rep_edge", ss, 59);
    tick(9);
    check("rep_c9", ss, 59);
    tick(1);
    check("rep_c10", ss, 0);
    tick(4);
    check("rep_c14", ss, 1);
    tick(15);
    check("rep_c29", ss, 4);
    tick(1);
    check("rep_c30", ss, 5);
    b[1] = 1'b0;
    tick(12);
    check("rep_release", ss, 5);
    b[1] = 1'b1;
    b[2] = 1'b1;
    tick(20);
    check("both_held", ss, 5);
    b = '0;
    tick(1);
    do_load("ld_up", 5, 1'b1);
    check("ld_up_ss", ss, 5);
    locked = 1'b1;
    b[0] = 1'b1;
    b[1] = 1'b1;
    b[3] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      check("lock_en", init_en, 0);
    end
    b[0] = 1'b0;
    b[3] = 1'b0;
    check("lock_field", field, 0);
    check("lock_ss", ss, 5);
    check("lock_tar", tar_sec, 5);
    locked = 1'b0;
    tick(4);
    check("unlock_held", ss, 5);
    check("unlock_en", init_en, 0);
    b[1] = 1'b0;
    tick(1);
    press(1);
    check("ss6", ss, 6);
    b[3] = 1'b1;
    tick(1);
    b[3] = 1'b0;
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("abort_tar", tar_sec, 0);
    check("abort_ss", ss, 0);
    for (int i = 0; i < 3; i++) begin
      check("abort_en", init_en, 0);
      tick(1);
    end
    press(1);
    check("abort_edit", ss, 1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
